// File: rtl/udp_port_rx.sv
// IPv4/UDP receive parser: assembles N-bit beats into bytes, validates headers, emits UDP payload bytes tagged by port_idx.
// Define UDP_RX_IP_CSUM_CHECK_EN to also reject frames with a bad IPv4 header checksum (drop reason 7).
module udp_port_rx #(
    parameter int          N         = 2,
    parameter int          NUM_PORTS = 4,
    parameter logic [15:0] PORT_BASE = 16'd5000,
    parameter logic [31:0] MY_IP     = 32'h12_12_6b_0d,
    localparam int         PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  axiid,
    input  logic          axiiv,
    output logic [7:0]    axiod,
    output logic          axiov,
    output logic          axio_last,
    output logic [PW-1:0] port_idx,
    output logic [31:0]   src_ip_out,
    output logic [15:0]   src_port_out,
    output logic [15:0]   payload_len_out,
    output logic          drop,
    output logic [2:0]    drop_reason
);
    localparam int BEATS = 8 / N;
    localparam int SW    = (N == 8) ? 1 : 8 - N;

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_IP_HDR    = 3'd2;
    localparam logic [2:0] S_UDP_HDR   = 3'd3;
    localparam logic [2:0] S_PAYLOAD   = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;

    logic [2:0]    r_state;
    logic [3:0]    r_beat_cnt;
    logic [SW-1:0] r_shift;
    logic [4:0]    r_byte_cnt;
    logic [7:0]    r_prev;
    logic [15:0]   r_total_len;
    logic [15:0]   r_src_port;
    logic [15:0]   r_dst_port;
    logic [15:0]   r_udp_len;
    logic [15:0]   r_remain;
    logic [31:0]   r_src_ip;
    logic [23:0]   r_dst_ip;

    logic [7:0]    w_byte;
    logic          w_byte_done;
    logic [2:0]    w_fail;
    logic [15:0]   w_port_off;
    logic          w_port_ok;
    logic          w_len_ok;
    logic          w_csum_bad;

    // First beat of a byte carries its most significant bits.
    generate
        if (N == 8) begin : g_full
            assign w_byte = axiid;
        end else begin : g_shift
            assign w_byte = {r_shift, axiid};
        end
    endgenerate

    assign w_byte_done = axiiv && (r_beat_cnt == 4'(BEATS - 1)) &&
                         (r_state != S_WAIT_IDLE) && (r_state != S_DRAIN);

    assign w_port_off = r_dst_port - PORT_BASE;
    assign w_port_ok  = (r_dst_port >= PORT_BASE) && (w_port_off < 16'(NUM_PORTS));
    assign w_len_ok   = (r_udp_len >= 16'd8) &&
                        (({1'b0, r_udp_len} + 17'd20) <= {1'b0, r_total_len});

`ifdef UDP_RX_IP_CSUM_CHECK_EN
    logic [15:0] r_csum;
    logic [16:0] w_csum_raw;
    logic [15:0] w_csum;

    // One's-complement add of each header word, folding the carry back in every step.
    assign w_csum_raw = {1'b0, (r_byte_cnt == 5'd1) ? 16'd0 : r_csum} + {1'b0, r_prev, w_byte};
    assign w_csum     = w_csum_raw[15:0] + {15'd0, w_csum_raw[16]};
    assign w_csum_bad = (w_csum != 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_byte_done && (r_state != S_PAYLOAD) && r_byte_cnt[0] && (r_byte_cnt <= 5'd19)) begin
            r_csum <= w_csum;
        end
    end
`else
    assign w_csum_bad = 1'b0;
`endif

    always_comb begin
        w_fail = 3'd0;
        case (r_byte_cnt)
            5'd0:  if (w_byte != 8'h45) w_fail = 3'd1;
            5'd9:  if (w_byte != 8'd17) w_fail = 3'd2;
            5'd19: begin
                if (w_csum_bad)                        w_fail = 3'd7;
                else if ({r_dst_ip, w_byte} != MY_IP)  w_fail = 3'd3;
            end
            5'd27: begin
                if (!w_port_ok)      w_fail = 3'd4;
                else if (!w_len_ok)  w_fail = 3'd5;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_WAIT_IDLE;
            r_beat_cnt      <= '0;
            r_shift         <= '0;
            r_byte_cnt      <= '0;
            r_prev          <= '0;
            r_total_len     <= '0;
            r_src_port      <= '0;
            r_dst_port      <= '0;
            r_udp_len       <= '0;
            r_remain        <= '0;
            r_src_ip        <= '0;
            r_dst_ip        <= '0;
            axiod           <= '0;
            axiov           <= 1'b0;
            axio_last       <= 1'b0;
            port_idx        <= '0;
            src_ip_out      <= '0;
            src_port_out    <= '0;
            payload_len_out <= '0;
            drop            <= 1'b0;
            drop_reason     <= '0;
        end else begin
            axiov     <= 1'b0;
            axio_last <= 1'b0;
            drop      <= 1'b0;
            case (r_state)
                S_WAIT_IDLE, S_DRAIN: begin
                    r_beat_cnt <= '0;
                    r_byte_cnt <= '0;
                    if (!axiiv) r_state <= S_IDLE;
                end
                default: begin
                    if (!axiiv) begin
                        // Frame ended before the datagram completed; any partial byte is lost.
                        r_beat_cnt <= '0;
                        if (r_state != S_IDLE) begin
                            drop        <= 1'b1;
                            drop_reason <= 3'd6;
                            r_state     <= S_DRAIN;
                        end
                    end else begin
                        if (r_state == S_IDLE) r_state <= S_IP_HDR;
                        r_shift <= w_byte[SW-1:0];
                        if (!w_byte_done) begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end else begin
                            r_beat_cnt <= '0;
                            r_prev     <= w_byte;
                            if (r_state == S_PAYLOAD) begin
                                axiov    <= 1'b1;
                                axiod    <= w_byte;
                                r_remain <= r_remain - 16'd1;
                                if (r_remain == 16'd1) begin
                                    axio_last <= 1'b1;
                                    r_state   <= S_DRAIN;
                                end
                            end else if (w_fail != 3'd0) begin
                                drop        <= 1'b1;
                                drop_reason <= w_fail;
                                r_state     <= S_DRAIN;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 5'd1;
                                case (r_byte_cnt)
                                    5'd3:  r_total_len <= {r_prev, w_byte};
                                    5'd12, 5'd13, 5'd14, 5'd15:
                                           r_src_ip <= {r_src_ip[23:0], w_byte};
                                    5'd16, 5'd17, 5'd18:
                                           r_dst_ip <= {r_dst_ip[15:0], w_byte};
                                    5'd19: r_state <= S_UDP_HDR;
                                    5'd21: r_src_port <= {r_prev, w_byte};
                                    5'd23: r_dst_port <= {r_prev, w_byte};
                                    5'd25: r_udp_len <= {r_prev, w_byte};
                                    5'd27: begin
                                        port_idx        <= w_port_off[PW-1:0];
                                        src_ip_out      <= r_src_ip;
                                        src_port_out    <= r_src_port;
                                        payload_len_out <= r_udp_len - 16'd8;
                                        r_remain        <= r_udp_len - 16'd8;
                                        r_state         <= (r_udp_len == 16'd8) ? S_DRAIN : S_PAYLOAD;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_port_rx.sv
// Randomized and directed frames for udp_port_rx (N=2), checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_udp_port_rx;
    localparam int          NUM_PORTS = 4;
    localparam logic [31:0] MY_IP     = 32'h12126b0d;

    typedef logic [7:0] byte_q_t [$];
    typedef struct { int cyc; bit is_drop; logic [7:0] val; bit last; } ev_t;
    typedef ev_t ev_q_t [$];
    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  proto;
        logic [15:0] tot_len;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [15:0] ulen;
        int          npl;
        logic [7:0]  pl [8];
        int          nfcs;
        bit          bad_csum;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  axiid = 2'd0;
    logic        axiiv = 1'b0;
    logic [7:0]  axiod;
    logic        axiov;
    logic        axio_last;
    logic [1:0]  port_idx;
    logic [31:0] src_ip_out;
    logic [15:0] src_port_out;
    logic [15:0] payload_len_out;
    logic        drop;
    logic [2:0]  drop_reason;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int start = 0;
    ev_t obs_q [$];

    logic [1:0]  e_pidx  = '0;
    logic [31:0] e_sip   = '0;
    logic [15:0] e_sport = '0;
    logic [15:0] e_plen  = '0;
    logic [2:0]  e_reason = '0;

    udp_port_rx #(.N(2), .NUM_PORTS(NUM_PORTS), .PORT_BASE(16'd5000), .MY_IP(MY_IP)) dut (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
        .axiod(axiod), .axiov(axiov), .axio_last(axio_last), .port_idx(port_idx),
        .src_ip_out(src_ip_out), .src_port_out(src_port_out), .payload_len_out(payload_len_out),
        .drop(drop), .drop_reason(drop_reason)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (axiov === 1'b1) begin
            e.cyc = cyc - start; e.is_drop = 1'b0; e.val = axiod; e.last = axio_last;
            obs_q.push_back(e);
        end
        if (drop === 1'b1) begin
            e.cyc = cyc - start; e.is_drop = 1'b1; e.val = {5'd0, drop_reason}; e.last = 1'b0;
            obs_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hdr_sum(input byte_q_t f);
        int s;
        s = 0;
        for (int i = 0; i < 10; i++) s += int'({f[2*i], f[2*i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
        return 16'(s);
    endfunction

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.b0 = 8'h45; c.proto = 8'd17; c.tot_len = 16'd32;
        c.src_ip = 32'h0a000001; c.dst_ip = MY_IP;
        c.sport = 16'd1234; c.dport = 16'd5002; c.ulen = 16'd12;
        c.npl = 4;
        c.pl[0] = 8'hDE; c.pl[1] = 8'hAD; c.pl[2] = 8'hBE; c.pl[3] = 8'hEF;
        for (int i = 4; i < 8; i++) c.pl[i] = 8'h00;
        c.nfcs = 4; c.bad_csum = 1'b0;
        return c;
    endfunction

    function automatic void build(input cfg_t c, output byte_q_t f);
        logic [15:0] cs;
        f = {};
        f.push_back(c.b0); f.push_back(8'h00);
        f.push_back(c.tot_len[15:8]); f.push_back(c.tot_len[7:0]);
        f.push_back(8'h12); f.push_back(8'h34); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'h40); f.push_back(c.proto); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(c.src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(c.dst_ip[8*i +: 8]);
        f.push_back(c.sport[15:8]); f.push_back(c.sport[7:0]);
        f.push_back(c.dport[15:8]); f.push_back(c.dport[7:0]);
        f.push_back(c.ulen[15:8]);  f.push_back(c.ulen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < c.npl; i++) f.push_back(c.pl[i]);
        for (int i = 0; i < c.nfcs; i++) f.push_back(8'($urandom));
        cs = ~hdr_sum(f);
        if (c.bad_csum) cs = 16'h0000;
        f[10] = cs[15:8];
        f[11] = cs[7:0];
    endfunction

    // Expected output events, in cycles counted from the first beat of the frame.
    function automatic void model(input byte_q_t f, input int nbeats, input int rst_at,
                                  output ev_q_t ex, output bit acc);
        int nb, fidx, code, plen, tot, ulen, dport;
        ev_t e;
        nb = nbeats / 4; ex = {}; acc = 1'b0; code = 0; fidx = 0;
        tot = int'({f[2], f[3]}); dport = int'({f[22], f[23]}); ulen = int'({f[24], f[25]});
        if (f[0] != 8'h45) begin code = 1; fidx = 0; end
        else if (f[9] != 8'd17) begin code = 2; fidx = 9; end
`ifdef UDP_RX_IP_CSUM_CHECK_EN
        else if (hdr_sum(f) != 16'hFFFF) begin code = 7; fidx = 19; end
`endif
        else if ({f[16], f[17], f[18], f[19]} != MY_IP) begin code = 3; fidx = 19; end
        else if (dport < 5000 || dport >= 5000 + NUM_PORTS) begin code = 4; fidx = 27; end
        else if (ulen < 8 || ulen > tot - 20) begin code = 5; fidx = 27; end
        e.is_drop = 1'b1; e.last = 1'b0;
        if (code != 0 && fidx < nb) begin
            e.cyc = 4*fidx + 3; e.val = 8'(code); ex.push_back(e);
        end else if (code != 0 || nb <= 27) begin
            e.cyc = nbeats; e.val = 8'd6; ex.push_back(e);
        end else begin
            acc = 1'b1;
            plen = ulen - 8;
            for (int i = 0; i < plen; i++) begin
                if (28 + i < nb) begin
                    e.is_drop = 1'b0; e.cyc = 4*(28+i) + 3; e.val = f[28+i]; e.last = (i == plen-1);
                    ex.push_back(e);
                end
            end
            if (28 + plen > nb) begin
                e.is_drop = 1'b1; e.cyc = nbeats; e.val = 8'd6; e.last = 1'b0; ex.push_back(e);
            end
        end
        while (ex.size() > 0 && ex[ex.size()-1].cyc >= rst_at) void'(ex.pop_back());
    endfunction

    task automatic run(input string name, input byte_q_t f, input int nbeats, input int ra, input int rb);
        ev_q_t ex;
        bit    acc;
        int    m;
        model(f, nbeats, ra, ex, acc);
        obs_q.delete();
        @(negedge clk);
        start = cyc + 1;
        for (int b = 0; b < nbeats; b++) begin
            axiiv = 1'b1;
            axiid = 2'(f[b/4] >> (6 - 2*(b%4)));
            rst   = (b >= ra && b < rb);
            @(negedge clk);
        end
        axiiv = 1'b0; axiid = 2'd0; rst = 1'b0;
        repeat (8) @(negedge clk);

        if (ra < nbeats) begin
            e_pidx = '0; e_sip = '0; e_sport = '0; e_plen = '0; e_reason = '0;
        end else begin
            if (acc) begin
                e_pidx  = 2'(int'({f[22], f[23]}) - 5000);
                e_sip   = {f[12], f[13], f[14], f[15]};
                e_sport = {f[20], f[21]};
                e_plen  = 16'(int'({f[24], f[25]}) - 8);
            end
            if (ex.size() > 0 && ex[ex.size()-1].is_drop) e_reason = ex[ex.size()-1].val[2:0];
        end

        chk({name, ".nev"}, 32'(obs_q.size()), 32'(ex.size()));
        m = (obs_q.size() < ex.size()) ? obs_q.size() : ex.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s.e%0d.cyc", name, i),  32'(obs_q[i].cyc),     32'(ex[i].cyc));
            chk($sformatf("%s.e%0d.drop", name, i), 32'(obs_q[i].is_drop), 32'(ex[i].is_drop));
            chk($sformatf("%s.e%0d.val", name, i),  32'(obs_q[i].val),     32'(ex[i].val));
            chk($sformatf("%s.e%0d.last", name, i), 32'(obs_q[i].last),    32'(ex[i].last));
        end
        chk({name, ".port_idx"}, 32'(port_idx),        32'(e_pidx));
        chk({name, ".src_ip"},   src_ip_out,           e_sip);
        chk({name, ".src_port"}, 32'(src_port_out),    32'(e_sport));
        chk({name, ".plen"},     32'(payload_len_out), 32'(e_plen));
        chk({name, ".reason"},   32'(drop_reason),     32'(e_reason));
    endtask

    initial begin
        cfg_t    c;
        byte_q_t f;
        int      nbeats;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.axiov",     32'(axiov), 0);
        chk("rst.axio_last", 32'(axio_last), 0);
        chk("rst.axiod",     32'(axiod), 0);
        chk("rst.drop",      32'(drop), 0);
        chk("rst.reason",    32'(drop_reason), 0);
        chk("rst.port_idx",  32'(port_idx), 0);
        chk("rst.src_ip",    src_ip_out, 0);
        chk("rst.plen",      32'(payload_len_out), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        c = base_cfg(); build(c, f); run("valid", f, 4*f.size(), 1 << 30, 1 << 30);
        chk("valid.idx2", 32'(port_idx), 2);
        chk("valid.len4", 32'(payload_len_out), 4);
        c = base_cfg(); c.dst_ip = 32'h12126b0e; build(c, f); run("bad_ip", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); c.dport = 16'd5004; build(c, f); run("port5004", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); c.dport = 16'd4999; build(c, f); run("port4999", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); build(c, f); run("trunc", f, 4*30, 1 << 30, 1 << 30);
        c = base_cfg(); build(c, f); run("after_trunc", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); c.b0 = 8'h46; build(c, f); run("b0_46", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); c.ulen = 16'd7; build(c, f); run("ulen7", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); c.ulen = 16'd8; c.npl = 0; c.tot_len = 16'd28; build(c, f);
        run("ulen8", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); build(c, f); run("rst_mid", f, 4*f.size(), 118, 122);
        c = base_cfg(); build(c, f); run("after_rst", f, 4*f.size(), 1 << 30, 1 << 30);
        c = base_cfg(); c.bad_csum = 1'b1; build(c, f); run("csum0", f, 4*f.size(), 1 << 30, 1 << 30);

        for (int t = 0; t < 40; t++) begin
            c = base_cfg();
            c.npl = $urandom_range(0, 8);
            for (int i = 0; i < 8; i++) c.pl[i] = 8'($urandom);
            c.ulen = 16'(8 + c.npl); c.tot_len = 16'(28 + c.npl);
            c.dport = 16'(5000 + $urandom_range(0, NUM_PORTS - 1));
            c.sport = 16'($urandom); c.src_ip = $urandom; c.nfcs = $urandom_range(0, 4);
            case ($urandom_range(0, 9))
                3: c.dst_ip = c.dst_ip ^ (32'd1 << $urandom_range(0, 31));
                4: c.dport = ($urandom_range(0, 1) == 1) ? 16'(5004 + $urandom_range(0, 100))
                                                         : 16'(4990 + $urandom_range(0, 9));
                5: begin c.b0 = 8'($urandom); if (c.b0 == 8'h45) c.b0 = 8'h44; end
                6: c.proto = 8'd6;
                7: c.ulen = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'(9 + c.npl);
                8: c.bad_csum = 1'b1;
                default: ;
            endcase
            build(c, f);
            nbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4*f.size() - 1) : 4*f.size();
            run($sformatf("rnd%0d", t), f, nbeats, 1 << 30, 1 << 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
